// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, constants, FSM encoding and the xtime helper
// Imported by mix_column_unit and mix_columns_ctrl.
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_col_t;
  typedef logic [7:0]   aes_byte_t;

  localparam int        AES_NUM_COLS = 4;
  localparam aes_byte_t AES_POLY_LOW = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic aes_byte_t xtime(input aes_byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY_LOW : 8'h00);
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// rtl/mix_column_unit.sv - combinational MixColumns transform of one 32-bit column
// With INV_MIX_COLUMNS_EN defined, an inv select chooses InvMixColumns instead.
module mix_column_unit
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
`ifdef INV_MIX_COLUMNS_EN
  input  logic        inv,
`endif
  output logic [31:0] col_out
);

  aes_byte_t a  [4];
  aes_byte_t x2 [4];
  aes_byte_t x3 [4];

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign a[i]  = col_in[31-8*i -: 8];
    assign x2[i] = xtime(a[i]);
    assign x3[i] = x2[i] ^ a[i];
  end

  aes_col_t fwd;
  assign fwd = {x2[0] ^ x3[1] ^ a[2]  ^ a[3],
                a[0]  ^ x2[1] ^ x3[2] ^ a[3],
                a[0]  ^ a[1]  ^ x2[2] ^ x3[3],
                x3[0] ^ a[1]  ^ a[2]  ^ x2[3]};

`ifdef INV_MIX_COLUMNS_EN
  aes_byte_t x4 [4];
  aes_byte_t x8 [4];
  aes_byte_t m9 [4];
  aes_byte_t mb [4];
  aes_byte_t md [4];
  aes_byte_t me [4];

  // Inverse coefficients built from the chained xtime outputs, no extra multipliers.
  for (genvar i = 0; i < 4; i++) begin : g_inv_byte
    assign x4[i] = xtime(x2[i]);
    assign x8[i] = xtime(x4[i]);
    assign m9[i] = x8[i] ^ a[i];
    assign mb[i] = x8[i] ^ x2[i] ^ a[i];
    assign md[i] = x8[i] ^ x4[i] ^ a[i];
    assign me[i] = x8[i] ^ x4[i] ^ x2[i];
  end

  aes_col_t rev;
  assign rev = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};

  assign col_out = inv ? rev : fwd;
`else
  assign col_out = fwd;
`endif

endmodule

// File: rtl/mix_columns_ctrl.sv
// rtl/mix_columns_ctrl.sv - iterative MixColumns sequencer, COLS_PER_CYCLE columns per clock
// Define INV_MIX_COLUMNS_EN to add the inv_mode port and the InvMixColumns path.
module mix_columns_ctrl
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
`ifdef INV_MIX_COLUMNS_EN
  input  logic         inv_mode,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_ctrl: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(AES_NUM_COLS - COLS_PER_CYCLE);

  mc_state_t  st;
  logic [1:0] col_cnt;
  aes_state_t data_q;
  aes_state_t rot_data;
  logic [32*COLS_PER_CYCLE-1:0] col_flat;
`ifdef INV_MIX_COLUMNS_EN
  logic inv_q;
`endif

  // Units always see the top columns; the register rotates left by the group each
  // cycle, so after the full pass every column is back in its original slot.
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    mix_column_unit u_col (
      .col_in  (data_q[127-32*g -: 32]),
`ifdef INV_MIX_COLUMNS_EN
      .inv     (inv_q),
`endif
      .col_out (col_flat[32*(COLS_PER_CYCLE-g)-1 -: 32])
    );
  end

  if (COLS_PER_CYCLE == AES_NUM_COLS) begin : g_rot_full
    assign rot_data = col_flat;
  end else begin : g_rot_part
    assign rot_data = {data_q[127-32*COLS_PER_CYCLE:0], col_flat};
  end

  assign state_out = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      col_cnt   <= 2'd0;
      data_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef INV_MIX_COLUMNS_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      case (st)
        IDLE: begin
          if (in_valid) begin
            data_q   <= state_in;
            col_cnt  <= 2'd0;
            st       <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef INV_MIX_COLUMNS_EN
            inv_q    <= inv_mode;
`endif
          end
        end
        RUN: begin
          data_q  <= rot_data;
          col_cnt <= col_cnt + STEP;
          if (col_cnt == LAST) begin
            st        <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            st        <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          st        <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_ctrl.sv
// tb/tb_mix_columns_ctrl.sv - scoreboard bench for mix_columns_ctrl at 1, 2 and 4 columns per cycle
// Covers INV_MIX_COLUMNS_EN when that macro is defined for the build.
module tb_mix_columns_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         iv   [3];
  logic         ir   [3];
  logic         ov   [3];
  logic         ordy [3];
  logic         bsy  [3];
  logic         im   [3];
  logic [127:0] si   [3];
  logic [127:0] so   [3];

  int checks = 0;
  int errors = 0;
  int lat_exp [3] = '{5, 3, 2};
  logic [127:0] q [$];

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] VEC_IN   = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] VEC_OUT  = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] C6_ALL   = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    mix_columns_ctrl #(.COLS_PER_CYCLE(1 << k)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[k]),
      .in_ready  (ir[k]),
      .state_in  (si[k]),
`ifdef INV_MIX_COLUMNS_EN
      .inv_mode  (im[k]),
`endif
      .out_valid (ov[k]),
      .out_ready (ordy[k]),
      .state_out (so[k]),
      .busy      (bsy[k])
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [7:0]   b [16];
    logic [7:0]   co [4];
    logic [127:0] t = s;
    logic [127:0] r = '0;
    logic [7:0]   acc;
    logic [1:0]   ci;
    logic [3:0]   bi;
    if (inv) begin
      co[0] = 8'h0e; co[1] = 8'h0b; co[2] = 8'h0d; co[3] = 8'h09;
    end else begin
      co[0] = 8'h02; co[1] = 8'h03; co[2] = 8'h01; co[3] = 8'h01;
    end
    for (int i = 0; i < 16; i++) begin
      b[i] = t[127:120];
      t = t << 8;
    end
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          ci = 2'(j - i);
          bi = 4'(4 * c + j);
          acc = acc ^ gmul(co[ci], b[bi]);
        end
        r = {r[119:0], acc};
      end
    end
    return r;
  endfunction

  task automatic accept(input int k, input logic [127:0] s, input logic inv);
    int n = 0;
    @(negedge clk);
    si[k] = s;
    im[k] = inv;
    iv[k] = 1'b1;
    while (ir[k] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ir[k] !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout dut%0d: in_ready=%b, required 1", k, ir[k]);
      iv[k] = 1'b0;
      return;
    end
    q.push_back(model(s, inv));
    @(negedge clk);
    iv[k] = 1'b0;
  endtask

  task automatic wait_out(input int k, output int lat, output logic [127:0] res);
    lat = 1;
    while (ov[k] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = so[k];
    if (ov[k] !== 1'b1) lat = -1;
  endtask

  task automatic retire(input int k);
    ordy[k] = 1'b1;
    @(negedge clk);
    ordy[k] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; im[k] = 1'b0; si[k] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks += 4;
      if (ir[k] !== 1'b1) begin errors++; $display("FAIL reset_in_ready dut%0d: got %b, required 1", k, ir[k]); end
      if (ov[k] !== 1'b0) begin errors++; $display("FAIL reset_out_valid dut%0d: got %b, required 0", k, ov[k]); end
      if (bsy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d: got %b, required 0", k, bsy[k]); end
      if (so[k] !== 128'h0) begin errors++; $display("FAIL reset_state_out dut%0d: got %h, required 0", k, so[k]); end
    end
  endtask

  task automatic test_vector(input int k, input logic [127:0] vin, input logic [127:0] vout);
    int lat;
    logic [127:0] res, exp;
    accept(k, vin, 1'b0);
    wait_out(k, lat, res);
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL vec_timeout dut%0d: out_valid never rose, required within %0d", k, lat_exp[k]);
      q.delete();
      return;
    end
    if (lat != lat_exp[k]) begin errors++; $display("FAIL vec_latency dut%0d: got %0d, required %0d", k, lat, lat_exp[k]); end
    exp = q.pop_front();
    checks += 2;
    if (res !== exp) begin errors++; $display("FAIL vec_model dut%0d: got %h, required %h", k, res, exp); end
    if (res !== vout) begin errors++; $display("FAIL vec_known dut%0d: got %h, required %h", k, res, vout); end
    retire(k);
  endtask

  task automatic test_backpressure;
    int lat;
    logic [127:0] res, exp;
    accept(0, VEC_IN, 1'b0);
    wait_out(0, lat, res);
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL bp_timeout: out_valid never rose, required within 5");
      q.delete();
      return;
    end
    exp = q.pop_front();
    if (res !== exp) begin errors++; $display("FAIL bp_value: got %h, required %h", res, exp); end
    for (int i = 0; i < 10; i++) begin
      checks += 3;
      if (so[0] !== exp) begin errors++; $display("FAIL bp_stable cycle %0d: got %h, required %h", i, so[0], exp); end
      if (ir[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d: got %b, required 0", i, ir[0]); end
      if (ov[0] !== 1'b1) begin errors++; $display("FAIL bp_out_valid cycle %0d: got %b, required 1", i, ov[0]); end
      iv[0] = (i == 3);
      si[0] = (i == 3) ? FIPS_IN : VEC_IN;
      @(negedge clk);
    end
    iv[0] = 1'b0;
    retire(0);
    for (int i = 0; i < 2; i++) begin
      checks += 3;
      if (ir[0] !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready +%0d: got %b, required 1", i, ir[0]); end
      if (ov[0] !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid +%0d: got %b, required 0", i, ov[0]); end
      if (bsy[0] !== 1'b0) begin errors++; $display("FAIL bp_release_busy +%0d: got %b, required 0", i, bsy[0]); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_run;
    accept(0, FIPS_IN, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    checks += 4;
    if (ir[0] !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b, required 1", ir[0]); end
    if (ov[0] !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b, required 0", ov[0]); end
    if (bsy[0] !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, required 0", bsy[0]); end
    if (so[0] !== 128'h0) begin errors++; $display("FAIL midrst_state_out: got %h, required 0", so[0]); end
    test_vector(0, C6_ALL, C6_ALL);
  endtask

  task automatic test_back_to_back;
    int sent = 0, got = 0, cyc = 0, last_t = -1;
    logic [127:0] s, exp;
    ordy[0] = 1'b1;
    im[0] = 1'b0;
    while (got < 8 && cyc < 200) begin
      if (ov[0] === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected: output %h with nothing outstanding", so[0]);
        end else begin
          exp = q.pop_front();
          if (so[0] !== exp) begin errors++; $display("FAIL b2b_value #%0d: got %h, required %h", got, so[0], exp); end
        end
        if (last_t >= 0) begin
          checks++;
          if (cyc - last_t != 6) begin errors++; $display("FAIL b2b_spacing #%0d: got %0d, required 6", got, cyc - last_t); end
        end
        last_t = cyc;
        got++;
      end
      if (sent < 8) begin
        iv[0] = 1'b1;
        if (ir[0] === 1'b1) begin
          s = {$urandom, $urandom, $urandom, $urandom};
          si[0] = s;
          q.push_back(model(s, 1'b0));
          sent++;
        end
      end else begin
        iv[0] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b0;
    checks++;
    if (got != 8) begin errors++; $display("FAIL b2b_count: got %0d results, required 8", got); end
    q.delete();
  endtask

`ifdef INV_MIX_COLUMNS_EN
  task automatic test_inverse;
    int lat;
    logic [127:0] res, exp;
    accept(0, FIPS_OUT, 1'b1);
    im[0] = 1'b0;
    wait_out(0, lat, res);
    checks++;
    if (lat != 5) begin errors++; $display("FAIL inv_latency: got %0d, required 5", lat); end
    if (lat < 0) begin q.delete(); return; end
    exp = q.pop_front();
    checks += 2;
    if (res !== exp) begin errors++; $display("FAIL inv_model: got %h, required %h", res, exp); end
    if (res !== FIPS_IN) begin errors++; $display("FAIL inv_known: got %h, required %h", res, FIPS_IN); end
    retire(0);
  endtask
`endif

  initial begin
    test_reset();
    test_vector(0, FIPS_IN, FIPS_OUT);
    for (int k = 0; k < 3; k++) test_vector(k, VEC_IN, VEC_OUT);
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
`ifdef INV_MIX_COLUMNS_EN
    test_inverse();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
